// File: rtl/mult_array_arbiter.sv
// Round-robin scheduler sharing one multi-lane multiplier array between two requesters.
// Latches the winner's operands, pulses start, waits out busy (with a watchdog) and returns tagged products.
module mult_array_arbiter #(
  parameter int N       = 16,
  parameter int LANES   = 9,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [N*LANES-1:0]   req0_a,
  input  logic [N*LANES-1:0]   req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [N*LANES-1:0]   req1_a,
  input  logic [N*LANES-1:0]   req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [N*LANES-1:0]   rsp_o,
  output logic                 rsp_err,
  output logic                 mul_start,
  output logic [N*LANES-1:0]   mul_a,
  output logic [N*LANES-1:0]   mul_b,
  input  logic [N*LANES-1:0]   mul_o,
  input  logic                 mul_busy
);

  localparam int W  = N * LANES;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q;
  logic            lastGrant_q;
  logic            opId_q;
  logic [W-1:0]    opA_q;
  logic [W-1:0]    opB_q;
  logic            mulStart_q;
  logic [CW-1:0]   waitCnt_q;
  logic            firstWait_q;
  logic            rspValid_q;
  logic            rspId_q;
  logic [W-1:0]    rspData_q;
  logic            rspErr_q;

  logic            grantValid_d;
  logic            grantId_d;

  // Grants only from IDLE with the array idle; on contention the requester that lost last time wins.
  always_comb begin
    grantValid_d = 1'b0;
    grantId_d    = 1'b0;
    if (state_q == IDLE && !mul_busy) begin
      if (req0_valid && req1_valid) begin
        grantValid_d = 1'b1;
        grantId_d    = ~lastGrant_q;
      end else if (req0_valid) begin
        grantValid_d = 1'b1;
        grantId_d    = 1'b0;
      end else if (req1_valid) begin
        grantValid_d = 1'b1;
        grantId_d    = 1'b1;
      end
    end
  end

  assign req0_ready = grantValid_d && !grantId_d;
  assign req1_ready = grantValid_d && grantId_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      opId_q      <= 1'b0;
      opA_q       <= '0;
      opB_q       <= '0;
      mulStart_q  <= 1'b0;
      waitCnt_q   <= '0;
      firstWait_q <= 1'b0;
      rspValid_q  <= 1'b0;
      rspId_q     <= 1'b0;
      rspData_q   <= '0;
      rspErr_q    <= 1'b0;
    end else begin
      mulStart_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantValid_d) begin
            opA_q       <= grantId_d ? req1_a : req0_a;
            opB_q       <= grantId_d ? req1_b : req0_b;
            opId_q      <= grantId_d;
            lastGrant_q <= grantId_d;
            mulStart_q  <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          waitCnt_q   <= '0;
          firstWait_q <= 1'b1;
          state_q     <= WAIT;
        end
        // The array registers busy, so its value in the first WAIT cycle is not yet meaningful.
        WAIT: begin
          if (firstWait_q) begin
            firstWait_q <= 1'b0;
            if (mul_busy) waitCnt_q <= waitCnt_q + CW'(1);
          end else if (!mul_busy) begin
            rspData_q  <= mul_o;
            rspErr_q   <= 1'b0;
            rspId_q    <= opId_q;
            rspValid_q <= 1'b1;
            opA_q      <= '0;
            opB_q      <= '0;
            state_q    <= RESP;
          end else if (waitCnt_q == TIMEOUT_C) begin
            rspData_q  <= '0;
            rspErr_q   <= 1'b1;
            rspId_q    <= opId_q;
            rspValid_q <= 1'b1;
            opA_q      <= '0;
            opB_q      <= '0;
            state_q    <= RESP;
          end else begin
            waitCnt_q <= waitCnt_q + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspErr_q   <= 1'b0;
            rspId_q    <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_start = mulStart_q;
  assign mul_a     = opA_q;
  assign mul_b     = opB_q;
  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_o     = rspData_q;
  assign rsp_err   = rspErr_q;

endmodule
